i2s_dac_tx: RTL
===============

Name: i2s_dac_tx

Overview:
- Transmit end of the audio path: takes processed stereo samples from the DSP subsystem and serializes them onto the audio codec DAC data line in I2S format.
- The codec is bus master and drives BCLK and DACLRCK. This block is the slave and runs entirely in the system clock domain.
- A one-deep holding register with a valid/ready handshake decouples the DSP sample timing from the codec frame timing.
- Emits a once-per-frame strobe that can pace the upstream sample producer.

Parameters:
- DATA_W, 16, sample width in bits; MSB is sent first.
- UNDERRUN_W, 8, width of the saturating underrun counter.

Ports:
- clk  input  1  system clock; frequency must be at least 4x the BCLK frequency.
- reset  input  1  asynchronous, active-low reset.
- aud_bclk  input  1  codec bit clock; asynchronous to clk.
- aud_daclrck  input  1  codec left/right clock; low = left channel, high = right channel; asynchronous to clk.
- left_sample  input  DATA_W  left-channel sample; two's complement.
- right_sample  input  DATA_W  right-channel sample; two's complement.
- sample_valid  input  1  producer presents a left/right pair.
- sample_ready  output  1  holding register empty; a pair is accepted when sample_valid and sample_ready are both high at a clk edge.
- aud_dacdat  output  1  serial DAC data.
- frame_start  output  1  one-clk pulse at the start of each left channel.
- underrun_count  output  UNDERRUN_W  number of frames that found the holding register empty; saturates at all-ones.

Behaviour:
- Reset (reset low, async): aud_dacdat=0, sample_ready=1, frame_start=0, underrun_count=0. Holding register, frame registers and shift register cleared; hold_full=0; bit counter marked done. Synchronizer and edge-history flops reset to 0.
- Synchronization: aud_bclk and aud_daclrck each pass through a 2-FF synchronizer. A BCLK falling edge is detected on the synchronized signal (previous=1, current=0) and yields a one-clk event fe.
- Per fe: sample synchronized LRCK into lr_now and compare with lr_prev, which was captured at the previous fe. All actions below occur only on fe cycles.
- LRCK 1->0 (frame start):
  - If hold_full: copy the holding register to frame_l/frame_r and clear hold_full.
  - Else: keep the previous frame_l/frame_r and increment underrun_count (saturating).
  - Load the shift register with the new frame_l; set bit_cnt=0; drive aud_dacdat=0 (I2S one-bit delay slot); pulse frame_start for this clk.
- LRCK 0->1: load the shift register with frame_r; bit_cnt=0; aud_dacdat=0 (delay slot).
- No LRCK change, bit_cnt<DATA_W: drive aud_dacdat = shift register MSB, shift left one bit, bit_cnt++.
- No LRCK change, bit_cnt=DATA_W (done): aud_dacdat=0 padding until the next LRCK change.
- Resulting timing: the MSB appears on the second BCLK falling edge after an LRCK transition, and the codec samples on BCLK rising edges. The output latency from the synchronized fe to aud_dacdat is 1 clk.
- Short channel slots (fewer than DATA_W+1 BCLKs per channel): an LRCK change always reloads, truncating the remaining LSBs. No error is flagged.
- Handshake:
  - sample_ready = !hold_full.
  - On acceptance, capture both samples and set hold_full=1.
- Acceptance in the same clk as a frame-start transfer:
  - If hold_full was 0: the underrun is counted, the new pair is captured into hold, and it is sent next frame.
  - If hold_full was 1: sample_ready is 0, so no capture occurs.
- sample_ready returns high the clk after the frame-start transfer.
- Startup: the first fe after reset only initializes lr_prev; a transition is detected only from the second fe onward. Until the first frame with data, silence (zeros) is transmitted.
- Reset asserted mid-frame: all outputs go to their reset values immediately. After release, transmission resumes at the next detected LRCK 1->0 edge.

Test Plan:
- Reset with BCLK running: aud_dacdat=0, sample_ready=1, underrun_count=0, frame_start never pulses before the first detected LRCK falling edge.
- Load L=0xA5C3, R=0x1234 before the frame; BCLK 64/frame (32 per channel):
  - After the LRCK fall: pad bit 0, then 1010010111000011, then 15 zeros.
  - After the LRCK rise: pad bit 0, then 0001001000110100, then zeros.
  - frame_start pulses exactly once, at the LRCK fall.
- Underrun: after the frame above, give no valid for 3 frames. Each frame repeats 0xA5C3/0x1234 and underrun_count reads 3. Force 300 underruns and check saturation at 255.
- Back-pressure: a valid pair is accepted and ready drops. A second pair with valid held high is not accepted until the clk after frame_start. The first pair appears in frame N+1, the second in frame N+2.
- Short slots, 16 BCLK per channel, L=0xFFFF: 15 ones are sent after the pad bit and the LSB is dropped at the reload.
- Reset pulse mid-left-channel: aud_dacdat=0 immediately. No output until the next LRCK fall after release, then zeros (hold empty, underrun_count=1).

Source files
------------

// File: rtl/i2s_dac_tx.sv
// I2S slave transmitter: serializes held stereo sample pairs onto the codec DAC data line,
// following codec-driven BCLK/DACLRCK that are synchronized into the system clock domain.
module i2s_dac_tx #(
  parameter int DATA_W     = 16,
  parameter int UNDERRUN_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  aud_bclk,
  input  logic                  aud_daclrck,
  input  logic [DATA_W-1:0]     left_sample,
  input  logic [DATA_W-1:0]     right_sample,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  aud_dacdat,
  output logic                  frame_start,
  output logic [UNDERRUN_W-1:0] underrun_count
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_W);

  logic                  bclk_meta_q, bclk_sync_q, bclk_prev_q;
  logic                  lrck_meta_q, lrck_sync_q;
  logic                  lr_prev_q, lr_prev_d;
  logic                  lr_seen_q, lr_seen_d;
  logic [DATA_W-1:0]     hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_W-1:0]     frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  dacdat_q, dacdat_d;
  logic                  frame_start_q, frame_start_d;
  logic [UNDERRUN_W-1:0] underrun_q, underrun_d;

  logic fe, lr_fall, lr_rise, accept;

  // Handshake: a pair transfers on any clk edge where sample_valid && sample_ready;
  // sample_ready is simply "holding register empty" and does not depend on sample_valid.
  assign accept  = sample_valid & ~hold_full_q;
  assign fe      = bclk_prev_q & ~bclk_sync_q;
  // lr_seen_q gates edge detection until the first fe has seeded lr_prev_q.
  assign lr_fall = fe & lr_seen_q & lr_prev_q & ~lrck_sync_q;
  assign lr_rise = fe & lr_seen_q & ~lr_prev_q & lrck_sync_q;

  assign sample_ready   = ~hold_full_q;
  assign aud_dacdat     = dacdat_q;
  assign frame_start    = frame_start_q;
  assign underrun_count = underrun_q;

  always_comb begin
    lr_prev_d     = lr_prev_q;
    lr_seen_d     = lr_seen_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    hold_full_d   = hold_full_q;
    frame_l_d     = frame_l_q;
    frame_r_d     = frame_r_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    dacdat_d      = dacdat_q;
    frame_start_d = lr_fall;
    underrun_d    = underrun_q;

    if (fe) begin
      lr_prev_d = lrck_sync_q;
      lr_seen_d = 1'b1;
    end

    if (accept) begin
      hold_l_d    = left_sample;
      hold_r_d    = right_sample;
      hold_full_d = 1'b1;
    end

    if (lr_fall) begin
      if (hold_full_q) begin
        frame_l_d   = hold_l_q;
        frame_r_d   = hold_r_q;
        hold_full_d = 1'b0;
        shift_d     = hold_l_q;
      end else begin
        shift_d = frame_l_q;
        if (underrun_q != '1) underrun_d = underrun_q + 1'b1;
      end
      bit_cnt_d = '0;
      dacdat_d  = 1'b0;
    end else if (lr_rise) begin
      shift_d   = frame_r_q;
      bit_cnt_d = '0;
      dacdat_d  = 1'b0;
    end else if (fe) begin
      if (bit_cnt_q < CNT_DONE) begin
        dacdat_d  = shift_q[DATA_W-1];
        shift_d   = {shift_q[DATA_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
      end else begin
        dacdat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_meta_q   <= 1'b0;
      bclk_sync_q   <= 1'b0;
      bclk_prev_q   <= 1'b0;
      lrck_meta_q   <= 1'b0;
      lrck_sync_q   <= 1'b0;
      lr_prev_q     <= 1'b0;
      lr_seen_q     <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      hold_full_q   <= 1'b0;
      frame_l_q     <= '0;
      frame_r_q     <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= CNT_DONE;
      dacdat_q      <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= '0;
    end else begin
      bclk_meta_q   <= aud_bclk;
      bclk_sync_q   <= bclk_meta_q;
      bclk_prev_q   <= bclk_sync_q;
      lrck_meta_q   <= aud_daclrck;
      lrck_sync_q   <= lrck_meta_q;
      lr_prev_q     <= lr_prev_d;
      lr_seen_q     <= lr_seen_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      hold_full_q   <= hold_full_d;
      frame_l_q     <= frame_l_d;
      frame_r_q     <= frame_r_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      dacdat_q      <= dacdat_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

endmodule
